// File: rtl/mat_result_reader_if.sv
// Bundle between the result reader, the multiplier's data RAM and the byte consumer.
//
// Stream handshake: o_valid/o_data come from the reader. A beat transfers on a
// rising edge where o_valid and i_ready are both high. While o_valid is high and
// i_ready is low, o_data holds and o_valid stays high. i_ready may toggle freely
// and never depends on o_valid for its legality.
interface mat_result_reader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              i_mm_busy;
    logic              i_dump;
    logic              o_dram_read;
    logic [ADDR_W-1:0] o_dram_addr;
    logic [DATA_W-1:0] i_dram_data;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_busy;
    logic              o_done;
    logic [DATA_W-1:0] o_checksum;
    logic [4:0]        o_index;

    // Reader side
    modport master (
        input  i_mm_busy, i_dump, i_dram_data, i_ready,
        output o_dram_read, o_dram_addr, o_data, o_valid,
               o_busy, o_done, o_checksum, o_index
    );

    // Environment side: multiplier, RAM and consumer
    modport slave (
        output i_mm_busy, i_dump, i_dram_data, i_ready,
        input  o_dram_read, o_dram_addr, o_data, o_valid,
               o_busy, o_done, o_checksum, o_index
    );
endinterface

// File: rtl/mat_result_reader.sv
// Reads the multiplier's result matrix out of the data RAM after a multiplication
// finishes (or on a manual dump request) and streams it out byte by byte while
// keeping a running XOR checksum. o_state exposes the FSM state for observation.
module mat_result_reader #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h0024,
    parameter int                NUM_ELEMS = 18
) (
    input  logic                i_clk,
    input  logic                i_rst,
    mat_result_reader_if.master bus,
    output logic [2:0]          o_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_RD    = 3'd2,
        S_LAT   = 3'd3,
        S_OUT   = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_ELEMS - 1);

    state_t            state_q, state_d;
    logic              busy_q;
    logic [4:0]        index_q, index_d;
    logic [DATA_W-1:0] checksum_d;

    assign o_state     = state_q;
    assign bus.o_index = index_q;

    // Next-state, next index and next checksum
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        checksum_d = bus.o_checksum;
        unique case (state_q)
            S_IDLE: begin
                // A manual dump takes priority over a coincident busy rising edge
                if (bus.i_dump) begin
                    state_d    = S_RD;
                    index_d    = '0;
                    checksum_d = '0;
                end else if (bus.i_mm_busy && !busy_q) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!bus.i_mm_busy) begin
                    state_d    = S_RD;
                    index_d    = '0;
                    checksum_d = '0;
                end
            end
            S_RD:  state_d = S_LAT;
            S_LAT: state_d = S_OUT;
            S_OUT: begin
                if (bus.i_ready) begin
                    checksum_d = bus.o_checksum ^ bus.o_data;
                    if (index_q == LAST_IDX) begin
                        index_d = '0;
                        state_d = S_FIN;
                    end else begin
                        index_d = index_q + 5'd1;
                        state_d = S_RD;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, index and registered outputs; outputs are decoded from the next
    // state so they line up with the state they belong to
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= S_IDLE;
            busy_q          <= 1'b0;
            index_q         <= '0;
            bus.o_dram_read <= 1'b0;
            bus.o_dram_addr <= '0;
            bus.o_data      <= '0;
            bus.o_valid     <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_done      <= 1'b0;
            bus.o_checksum  <= '0;
        end else begin
            state_q         <= state_d;
            busy_q          <= bus.i_mm_busy;
            index_q         <= index_d;
            bus.o_checksum  <= checksum_d;
            bus.o_dram_read <= (state_d == S_RD);
            // Address wraps naturally at 2^ADDR_W; held outside RD
            if (state_d == S_RD) begin
                bus.o_dram_addr <= BASE_ADDR + ADDR_W'(index_d);
            end
            // RAM data is valid the cycle after the strobe, i.e. during LAT
            if (state_q == S_LAT) begin
                bus.o_data <= bus.i_dram_data;
            end
            bus.o_valid <= (state_d == S_OUT);
            bus.o_busy  <= (state_d == S_RD) || (state_d == S_LAT) ||
                           (state_d == S_OUT) || (state_d == S_FIN);
            bus.o_done  <= (state_d == S_FIN);
        end
    end
endmodule

// File: tb/tb_mat_result_reader.sv
// Directed bench for mat_result_reader: auto readout, backpressure, manual dump,
// simultaneous triggers, reset mid-readout and address wrap.
module tb_mat_result_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mat_result_reader_if #(.ADDR_W(16), .DATA_W(8)) ifc ();
    mat_result_reader_if #(.ADDR_W(16), .DATA_W(8)) ifw ();
    logic [2:0] st, st_w;

    mat_result_reader #(.ADDR_W(16), .DATA_W(8), .BASE_ADDR(16'h0024), .NUM_ELEMS(18)) dut (
        .i_clk(clk), .i_rst(rst), .bus(ifc.master), .o_state(st)
    );
    mat_result_reader #(.ADDR_W(16), .DATA_W(8), .BASE_ADDR(16'hFFFE), .NUM_ELEMS(4)) dut_w (
        .i_clk(clk), .i_rst(rst), .bus(ifw.master), .o_state(st_w)
    );

    // RAM model: registered read; junk value when not strobed
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        ifc.i_dram_data <= ifc.o_dram_read ? mem[ifc.o_dram_addr] : 8'hEE;
        ifw.i_dram_data <= ifw.o_dram_read ? mem[ifw.o_dram_addr] : 8'hEE;
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  beat_q[$];
    logic [15:0] addr_q[$];
    int n_done, rd_first, done_at, stab_err, vld_after_hs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs the main DUT for one readout, driving i_ready at ready_pct duty,
    // optionally pulsing i_dump during the readout, recording beats/addresses.
    task automatic collect(input int ready_pct, input bit dump_noise);
        bit         prev_valid = 1'b0;
        bit         prev_ready = 1'b0;
        logic [7:0] prev_data  = '0;
        bit         r;
        int         post = 0;
        beat_q.delete();
        addr_q.delete();
        n_done = 0; rd_first = -1; done_at = -1; stab_err = 0; vld_after_hs = 0;
        for (int c = 0; c < 3000 && post < 3; c++) begin
            @(negedge clk);
            if (ifc.o_dram_read) begin
                addr_q.push_back(ifc.o_dram_addr);
                if (rd_first < 0) rd_first = c;
            end
            if (ifc.o_done) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            ifc.i_dump = dump_noise && (done_at < 0) && (c % 17 == 5);
            if (prev_valid && !prev_ready && (ifc.o_valid !== 1'b1 || ifc.o_data !== prev_data))
                stab_err++;
            if (prev_valid && prev_ready && ifc.o_valid) vld_after_hs++;
            r = ($urandom_range(0, 99) < ready_pct);
            ifc.i_ready = r;
            if (ifc.o_valid && r) beat_q.push_back(ifc.o_data);
            prev_valid = ifc.o_valid;
            prev_ready = r;
            prev_data  = ifc.o_data;
            if (done_at >= 0) post++;
        end
        ifc.i_ready = 1'b1;
        ifc.i_dump  = 1'b0;
    endtask

    task automatic check_run(input string tag, input bit check_timing);
        check({tag, " beats"}, beat_q.size(), 18);
        for (int i = 0; i < beat_q.size() && i < 18; i++)
            check($sformatf("%s beat%0d", tag, i), beat_q[i], exp_q[i]);
        check({tag, " reads"}, addr_q.size(), 18);
        for (int i = 0; i < addr_q.size() && i < 18; i++)
            check($sformatf("%s addr%0d", tag, i), addr_q[i], 16'h0024 + 16'(i));
        check({tag, " done_pulses"}, n_done, 1);
        check({tag, " checksum"}, ifc.o_checksum, 8'hFA);
        check({tag, " stable"}, stab_err, 0);
        check({tag, " valid_drop"}, vld_after_hs, 0);
        check({tag, " first_rd"}, rd_first, 0);
        // first RD cycle through the o_done cycle, inclusive: 3*18+1
        if (check_timing) check({tag, " latency"}, done_at - rd_first + 1, 55);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  wb[$];
        logic [15:0] wa[$];
        int          wdone;
        bit          found;

        exp_q = '{8'h7C, 8'h2D, 8'hC2, 8'h49, 8'hC4, 8'h31, 8'h44, 8'h43, 8'hCB,
                  8'h58, 8'h69, 8'h5F, 8'hDC, 8'h7D, 8'h1F, 8'hB1, 8'hBF, 8'hC7};
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        for (int i = 0; i < 18; i++) mem[16'h0024 + i] = exp_q[i];
        mem[16'hFFFE] = 8'hA1; mem[16'hFFFF] = 8'hB2;
        mem[16'h0000] = 8'hC3; mem[16'h0001] = 8'hD4;

        ifc.i_mm_busy = 0; ifc.i_dump = 0; ifc.i_ready = 1;
        ifw.i_mm_busy = 0; ifw.i_dump = 0; ifw.i_ready = 1;

        // Reset values
        cycles(3);
        check("rst state", st, 3'd0);
        check("rst read", ifc.o_dram_read, 0);
        check("rst addr", ifc.o_dram_addr, 16'h0000);
        check("rst data", ifc.o_data, 8'h00);
        check("rst valid", ifc.o_valid, 0);
        check("rst busy", ifc.o_busy, 0);
        check("rst done", ifc.o_done, 0);
        check("rst checksum", ifc.o_checksum, 8'h00);
        check("rst index", ifc.o_index, 5'd0);
        rst = 1'b0;
        cycles(2);

        // Auto readout after a 100-cycle multiplication
        ifc.i_mm_busy = 1;
        cycles(100);
        check("auto armed", st, 3'd1);
        check("auto armed busy", ifc.o_busy, 0);
        check("auto armed read", ifc.o_dram_read, 0);
        ifc.i_mm_busy = 0;
        collect(100, 1'b0);
        check_run("auto", 1'b1);
        cycles(4);
        check("auto idle", st, 3'd0);
        check("auto checksum hold", ifc.o_checksum, 8'hFA);

        // Backpressure at ~30% ready
        ifc.i_dump = 1;
        collect(30, 1'b0);
        check_run("bp", 1'b0);
        cycles(2);

        // Manual dump with dump pulses during the readout
        ifc.i_dump = 1;
        collect(100, 1'b1);
        check_run("dump", 1'b1);
        cycles(2);

        // Dump and busy rising together: immediate readout, no stale edge after
        ifc.i_dump = 1;
        ifc.i_mm_busy = 1;
        collect(100, 1'b0);
        check_run("simul", 1'b1);
        check("simul no armed", st, 3'd0);
        ifc.i_mm_busy = 0;
        cycles(2);

        // Dump while ARMED is ignored
        ifc.i_mm_busy = 1;
        cycles(1);
        check("armed entry", st, 3'd1);
        ifc.i_dump = 1;
        cycles(1);
        ifc.i_dump = 0;
        check("armed dump ignored", st, 3'd1);
        check("armed no read", ifc.o_dram_read, 0);
        cycles(3);
        ifc.i_mm_busy = 0;
        collect(100, 1'b0);
        check_run("armed", 1'b1);
        cycles(2);

        // Reset while presenting element 5
        ifc.i_dump = 1;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            ifc.i_dump = 0;
            if (ifc.o_valid && ifc.o_index == 5'd5) found = 1'b1;
            else ifc.i_ready = 1;
        end
        check("midrst reached", found, 1);
        check("midrst data", ifc.o_data, 8'h31);
        ifc.i_ready = 0;
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        ifc.i_ready = 1;
        check("midrst state", st, 3'd0);
        check("midrst valid", ifc.o_valid, 0);
        check("midrst busy", ifc.o_busy, 0);
        check("midrst done", ifc.o_done, 0);
        check("midrst checksum", ifc.o_checksum, 8'h00);
        check("midrst index", ifc.o_index, 5'd0);
        check("midrst addr", ifc.o_dram_addr, 16'h0000);
        check("midrst data0", ifc.o_data, 8'h00);
        cycles(2);
        check("midrst no late done", ifc.o_done, 0);
        ifc.i_dump = 1;
        collect(100, 1'b0);
        check_run("restart", 1'b1);

        // Address wrap on the second instance
        ifw.i_dump = 1;
        wdone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            ifw.i_dump = 0;
            if (ifw.o_dram_read) wa.push_back(ifw.o_dram_addr);
            if (ifw.o_valid) wb.push_back(ifw.o_data);
            if (ifw.o_done) wdone++;
        end
        check("wrap reads", wa.size(), 4);
        check("wrap beats", wb.size(), 4);
        if (wa.size() == 4) begin
            check("wrap addr0", wa[0], 16'hFFFE);
            check("wrap addr1", wa[1], 16'hFFFF);
            check("wrap addr2", wa[2], 16'h0000);
            check("wrap addr3", wa[3], 16'h0001);
        end
        if (wb.size() == 4) begin
            check("wrap beat0", wb[0], 8'hA1);
            check("wrap beat3", wb[3], 8'hD4);
        end
        check("wrap done", wdone, 1);
        check("wrap checksum", ifw.o_checksum, 8'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
